pattern_tx: RTL
===============

PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter IDLE_LVL, default 1'b1: level driven on ser_out whenever no pattern bit is being sent.
REQ-002 Port clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  request to send a frame; sampled only in IDLE.
REQ-005 Port pattern  input  8  bit pattern; captured on the accepted start edge.
REQ-006 Port len  input  3  pattern length minus one (0..7 = 1..8 bits); captured with pattern.
REQ-007 Port reps  input  4  repetitions minus one (0..15 = 1..16 sends); captured with pattern.
REQ-008 Port abort  input  1  synchronous cancel of the frame in progress.
REQ-009 Port ser_out  output  1  serial pattern bit; registered.
REQ-010 Port bit_valid  output  1  high when ser_out carries a pattern bit; registered.
REQ-011 Port busy  output  1  high in SEND and GAP; registered.
REQ-012 Port done  output  1  one-cycle pulse at normal frame completion; registered.

Function
REQ-013 The block SHALL be a Moore FSM with states IDLE, SEND, GAP, DONE; every output SHALL be a function of registered state only.
REQ-014 IDLE: start=1 at edge k SHALL capture pattern/len/reps, load bit index = len and repeat counter = reps, and enter SEND; start=0 SHALL keep IDLE.
REQ-015 Latency: first bit SHALL appear on ser_out in the cycle after edge k (one-cycle start-to-data latency).
REQ-016 SEND: ser_out = captured pattern[bit index], bit_valid=1, busy=1; bits SHALL be sent MSB-first from index len down to 0, one per cycle.
REQ-017 SEND at index 0: repeat counter >0 SHALL decrement it, reload index = len, and enter GAP; repeat counter =0 SHALL enter DONE.
REQ-018 GAP: exactly one cycle, ser_out=IDLE_LVL, bit_valid=0, busy=1, then SEND.
REQ-019 DONE: exactly one cycle, done=1, busy=0, bit_valid=0, ser_out=IDLE_LVL, then IDLE; start during DONE SHALL be ignored.
REQ-020 Frame duration SHALL be (len+1)*(reps+1) + reps cycles from first bit to last cycle of busy, followed by one DONE cycle.
REQ-021 start while busy SHALL be ignored; pattern/len/reps changes while busy SHALL NOT affect the frame in progress.
REQ-022 abort=1 in SEND or GAP SHALL force IDLE at the next edge with no done pulse; abort in IDLE or DONE SHALL have no effect; abort has priority over all SEND/GAP transitions.
REQ-023 abort and start both high in IDLE: start SHALL be accepted (abort ignored in IDLE).
REQ-024 len=0 SHALL send a 1-bit pattern (pattern[0]); reps=15 SHALL send 16 copies with 15 GAP cycles.
REQ-025 Illegal/unreachable state encodings SHALL return to IDLE at the next edge.

Reset
REQ-026 reset=1 SHALL immediately, without waiting for clk, force IDLE, ser_out=IDLE_LVL, bit_valid=0, busy=0, done=0, counters to 0.
REQ-027 reset asserted mid-frame SHALL discard the frame; no done pulse SHALL follow its release.
REQ-028 After reset release, the first accepted start SHALL behave identically to one issued after a completed frame.

Verification
REQ-029 pattern=8'h09, len=4, reps=0, start 1 cycle -> ser_out 0,1,0,0,1 with bit_valid=1 for 5 cycles, then done=1 one cycle, busy high exactly 5 cycles.
REQ-030 pattern=8'hA5, len=7, reps=1 -> 1,0,1,0,0,1,0,1, one GAP cycle (ser_out=1, bit_valid=0), same 8 bits repeated, done after 17 busy cycles.
REQ-031 pattern=8'h01, len=0, reps=2 -> 1,gap,1,gap,1, then done; busy 5 cycles.
REQ-032 len=7 frame, abort asserted during 4th bit -> IDLE next cycle, ser_out=IDLE_LVL, done never pulses; new start then succeeds.
REQ-033 Async reset pulse between clock edges during SEND -> outputs reach reset values before next edge; no done afterwards.
REQ-034 start held high continuously with reps=0, len=1 -> frames separated by DONE+IDLE cycles; pattern change during frame not reflected until next frame.

Source files
------------

// File: rtl/pattern_tx_if.sv
// Request/serial-output bundle for pattern_tx.
// Valid/ready: start is a request that is taken only while busy and done are both low.
// There is no backpressure. bit_valid marks every cycle in which ser_out carries a pattern bit.
interface pattern_tx_if;
   logic       start;
   logic [7:0] pattern;
   logic [2:0] len;
   logic [3:0] reps;
   logic       abort;
   logic       ser_out;
   logic       bit_valid;
   logic       busy;
   logic       done;

   modport master (
      output start, pattern, len, reps, abort,
      input  ser_out, bit_valid, busy, done
   );

   modport slave (
      input  start, pattern, len, reps, abort,
      output ser_out, bit_valid, busy, done
   );
endinterface

// File: rtl/pattern_tx.sv
// Repeating serial pattern transmitter: sends len+1 bits MSB-first, reps+1 times,
// with one idle gap cycle between copies and a one-cycle done pulse at the end.
module pattern_tx #(
   parameter logic IDLE_LVL = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   pattern_tx_if.slave   bus,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t     state, state_n;
   logic [2:0] idx, idx_n;
   logic [2:0] len_q, len_n;
   logic [3:0] rep, rep_n;
   logic [7:0] pat_q, pat_n;
   logic       ser_q, ser_n;
   logic       bv_q, bv_n;
   logic       busy_q, busy_n;
   logic       done_q, done_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         idx    <= '0;
         len_q  <= '0;
         rep    <= '0;
         pat_q  <= '0;
         ser_q  <= IDLE_LVL;
         bv_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         len_q  <= len_n;
         rep    <= rep_n;
         pat_q  <= pat_n;
         ser_q  <= ser_n;
         bv_q   <= bv_n;
         busy_q <= busy_n;
         done_q <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      len_n   = len_q;
      rep_n   = rep;
      pat_n   = pat_q;
      case (state)
         S_IDLE: begin
            // abort is deliberately not looked at here: a start is always taken in IDLE
            if (bus.start) begin
               state_n = S_SEND;
               pat_n   = bus.pattern;
               len_n   = bus.len;
               idx_n   = bus.len;
               rep_n   = bus.reps;
            end
         end
         S_SEND: begin
            if (bus.abort) begin
               state_n = S_IDLE;
            end else if (idx != 3'd0) begin
               idx_n = idx - 3'd1;
            end else if (rep != 4'd0) begin
               rep_n   = rep - 4'd1;
               idx_n   = len_q;
               state_n = S_GAP;
            end else begin
               state_n = S_DONE;
            end
         end
         S_GAP:   state_n = bus.abort ? S_IDLE : S_SEND;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they become flops aligned with state
      ser_n  = IDLE_LVL;
      bv_n   = 1'b0;
      busy_n = 1'b0;
      done_n = 1'b0;
      case (state_n)
         S_SEND: begin
            ser_n  = pat_n[idx_n];
            bv_n   = 1'b1;
            busy_n = 1'b1;
         end
         S_GAP:   busy_n = 1'b1;
         S_DONE:  done_n = 1'b1;
         default: ;
      endcase
   end

   assign bus.ser_out   = ser_q;
   assign bus.bit_valid = bv_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign state_dbg     = state;

endmodule
